fifo_uart_tx: RTL and testbench

Read-side drain stage for the 16-entry byte FIFO. It pulls bytes one at a time through the FIFO's read strobe and serializes each as an asynchronous 8N1 UART frame, LSB first, on a single output line. It sits directly downstream of the FIFO's `rd`/`empty`/`dout` ports. It also monitors the upstream write strobe, because the FIFO gives writes priority and silently drops a read issued in the same cycle.

---
 rtl/fifo_uart_tx.sv | 142 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter: pulls one byte per frame and serializes it LSB first.
// Define FIFO_UART_TX_PARITY_EN to append an even-parity bit after D7 (8E1 instead of 8N1).
`timescale 1ns/1ps
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic       fifo_wr,
   input  logic [7:0] fifo_dout,
   output logic       fifo_rd,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

`ifdef FIFO_UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, CAP, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, CAP, START, DATA, STOP} state_t;
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             wrap;
`ifdef FIFO_UART_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      done_d  = 1'b0;
      fifo_rd = 1'b0;
      wrap    = (cnt_q == CNT_MAX);
`ifdef FIFO_UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      // The FIFO drops a read that collides with a write, so never request then.
      case (state_q)
         IDLE: begin
            fifo_rd = !rst && !fifo_empty && !fifo_wr;
            if (fifo_rd) state_d = CAP;
         end
         CAP: begin
            shreg_d = fifo_dout;
            cnt_d   = '0;
            bit_d   = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_d   = ^fifo_dout;
`endif
            state_d = START;
         end
         START: begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (wrap) state_d = DATA;
         end
         DATA: begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (wrap) begin
               shreg_d = shreg_q >> 1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (wrap) state_d = STOP;
         end
`endif
         STOP: begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (wrap) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level is derived from the next state so tx is registered without extra lag.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:  tx_d = 1'b0;
         DATA:   tx_d = shreg_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: tx_d = par_d;
`endif
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign tx_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO, scoreboard of written bytes, per-cycle line monitor.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
   localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic fifo_empty = 1'b1;
   logic fifo_wr = 1'b0;
   logic [7:0] fifo_dout = 8'h00;
   logic [7:0] wdata = 8'h00;
   logic fifo_rd, tx, busy, tx_done;

   logic rd_s = 1'b0, wr_s = 1'b0;
   logic [7:0] wd_s = 8'h00;
   logic [7:0] mem[$];
   logic [7:0] exp_q[$];
   logic [7:0] cur = 8'h00;

   int cyc = 0;
   int busy_until = 0;
   int fstart = 1;
   int done_cyc = -1;
   int n_rd = 0, n_done = 0;
   int n_vec = 0, n_err = 0;

   fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_wr(fifo_wr),
      .fifo_dout(fifo_dout), .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .tx_done(tx_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // 16-entry FIFO with registered read data; a write wins over a same-cycle read
   always @(posedge clk) begin
      if (wr_s) begin
         if (mem.size() < 16) mem.push_back(wd_s);
      end else if (rd_s && mem.size() > 0) begin
         fifo_dout <= mem.pop_front();
      end
      fifo_empty <= (mem.size() == 0);
   end

   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (NB == 11 && idx == 9) return ^b;
      return 1'b1;
   endfunction

   task automatic chk(input string nm, input logic act, input logic req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         if (n_err <= 30) $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, req);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s got=%0d want=%0d", nm, act, req);
      end
   endtask

   // Monitor: expected line behaviour from the frame rules, compared every cycle
   initial begin
      bit idle, exp_rd;
      int k;
      forever begin
         @(negedge clk);
         rd_s = fifo_rd;
         wr_s = fifo_wr;
         wd_s = wdata;
         if (rst) begin
            chk("rd_in_reset", fifo_rd, 1'b0);
            busy_until = cyc;
            fstart     = cyc + 1;
            done_cyc   = -1;
         end else begin
            idle   = (cyc > busy_until);
            exp_rd = idle && !fifo_empty && !fifo_wr;
            chk("fifo_rd", fifo_rd, exp_rd);
            if (cyc >= fstart && cyc <= busy_until) begin
               k = cyc - fstart;
               chk("tx_frame", tx, frame_bit(cur, k / CPB));
               chk("busy_frame", busy, 1'b1);
            end else begin
               chk("tx_idle", tx, 1'b1);
               if (idle && !fifo_rd) chk("busy_idle", busy, 1'b0);
            end
            chk("tx_done", tx_done, (cyc == done_cyc));
            if (tx_done) n_done++;
            if (fifo_rd) begin
               n_rd++;
               if (exp_q.size() == 0) begin
                  chk("read_without_data", 1'b1, 1'b0);
               end else begin
                  cur = exp_q.pop_front();
               end
               fstart     = cyc + 2;
               busy_until = cyc + 1 + NB * CPB;
               done_cyc   = busy_until + 1;
            end
         end
      end
   end

   task automatic put(input logic [7:0] b);
      @(posedge clk); #1;
      fifo_wr = 1'b1;
      wdata   = b;
      exp_q.push_back(b);
   endtask

   task automatic wr_off();
      @(posedge clk); #1;
      fifo_wr = 1'b0;
   endtask

   task automatic drain(input string nm);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || mem.size() != 0 || cyc <= done_cyc + 1) && t < 4000) begin
         @(negedge clk);
         t++;
      end
      chk_int({nm, "_drain_timeout"}, int'(t >= 4000), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int r0, d0, t, gap;
      #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_tx", tx, 1'b1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", tx_done, 1'b0);
      chk("reset_rd", fifo_rd, 1'b0);

      r0 = n_rd;
      repeat (100) @(posedge clk);
      #1 chk_int("empty_reads", n_rd - r0, 0);

      r0 = n_rd; d0 = n_done;
      put(8'hA5); wr_off();
      drain("single");
      chk_int("single_reads", n_rd - r0, 1);
      chk_int("single_done", n_done - d0, 1);

      r0 = n_rd; d0 = n_done;
      put(8'hA5); put(8'h07); wr_off();
      drain("pair");
      chk_int("pair_reads", n_rd - r0, 2);
      chk_int("pair_done", n_done - d0, 2);

      r0 = n_rd; d0 = n_done;
      put(8'h01); put(8'h80); put(8'hFF); wr_off();
      drain("b2b");
      chk_int("b2b_reads", n_rd - r0, 3);
      chk_int("b2b_done", n_done - d0, 3);

      r0 = n_rd; d0 = n_done;
      for (int i = 0; i < 6; i++) put(8'h10 + 8'(i));
      wr_off();
      @(negedge clk);
      chk("collision_release", fifo_rd, 1'b1);
      drain("collision");
      chk_int("collision_reads", n_rd - r0, 6);
      chk_int("collision_done", n_done - d0, 6);

      r0 = n_rd; d0 = n_done;
      put(8'h3C); put(8'h5A); wr_off();
      t = 0;
      do begin @(negedge clk); t++; end while (!fifo_rd && t < 200);
      chk_int("reset_test_rd_timeout", int'(t >= 200), 0);
      repeat (3 + 4 * CPB) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midreset_tx", tx, 1'b1);
      chk("midreset_busy", busy, 1'b0);
      chk("midreset_done", tx_done, 1'b0);
      drain("midreset");
      chk_int("midreset_reads", n_rd - r0, 2);
      chk_int("midreset_done_cnt", n_done - d0, 1);

      r0 = n_rd; d0 = n_done;
      for (int i = 0; i < 40; i++) begin
         gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
         if (gap != 0 || mem.size() >= 10) begin
            wr_off();
            repeat (gap) @(posedge clk);
            t = 0;
            while (mem.size() >= 10 && t < 2000) begin @(posedge clk); t++; end
         end
         put(8'($urandom_range(0, 255)));
      end
      wr_off();
      drain("random");
      chk_int("random_reads", n_rd - r0, 40);
      chk_int("random_done", n_done - d0, 40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
